// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module  : fetch_queue_pkg
// Brief   : Shared branch-predictor / fetch packet types for the fetch queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam int LPHT_ADDR_WIDTH = 10;
  localparam int FQ_DEPTH        = 4;
  localparam int PC_W            = 30;

  // One prediction slot as produced by the branch predictor.
  typedef struct packed {
    logic                       valid;
    logic [31:2]                npc;
    logic [1:0]                 lphr;
    logic [LPHT_ADDR_WIDTH-1:0] lphr_index;
  } bpu_predict_t;

  typedef struct packed {
    logic [31:2]        pc;
    bpu_predict_t [1:0] predict;
  } fetch_pkt_t;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module  : fetch_queue
// Brief   : FWFT decoupling FIFO between branch predictor and I-cache fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  input  logic [PC_W-1:0]         in_pc_i,
  input  bpu_predict_t [1:0]      in_predict_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [PC_W-1:0]         out_pc_o,
  output bpu_predict_t [1:0]      out_predict_o,
  input  logic                    out_ready_i,
  output logic [PTR_W:0]          count_o
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  fetch_pkt_t       r_mem [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  fetch_pkt_t       w_in_pkt;
  fetch_pkt_t       w_head;

  // Ready depends only on registered occupancy, never on out_ready_i.
  assign w_full   = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = in_valid_i & ~w_full;
  assign w_pop    = out_ready_i & ~w_empty;

  always_comb begin
    w_in_pkt         = '0;
    w_in_pkt.pc      = in_pc_i;
    w_in_pkt.predict = in_predict_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally not reset; stale entries are masked by out_valid_o.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_pkt;
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign in_ready_o    = ~w_full;
  assign out_valid_o   = ~w_empty;
  assign out_pc_o      = w_head.pc;
  assign out_predict_o = w_head.predict;
  assign count_o       = r_count;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= (PTR_W+1)'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && w_empty));

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Scoreboard testbench for fetch_queue with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush_i = 1'b0;
  logic               in_valid_i = 1'b0;
  logic [PC_W-1:0]    in_pc_i = '0;
  bpu_predict_t [1:0] in_predict_i = '0;
  logic               in_ready_o;
  logic               out_valid_o;
  logic [PC_W-1:0]    out_pc_o;
  bpu_predict_t [1:0] out_predict_o;
  logic               out_ready_i = 1'b0;
  logic [2:0]         count_o;

  int n_checks = 0;
  int n_pass   = 0;
  fetch_pkt_t exp_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_pc_i      (in_pc_i),
    .in_predict_i (in_predict_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_pc_o     (out_pc_o),
    .out_predict_o(out_predict_o),
    .out_ready_i  (out_ready_i),
    .count_o      (count_o)
  );

  // Deterministic prediction payload derived from the pc; slot 1 invalid on odd pcs.
  function automatic bpu_predict_t [1:0] mk_pred(input logic [PC_W-1:0] pc);
    bpu_predict_t [1:0] p;
    p[0].valid      = 1'b1;
    p[0].npc        = pc + 30'd4;
    p[0].lphr       = pc[1:0];
    p[0].lphr_index = pc[9:0] ^ 10'h155;
    p[1].valid      = ~pc[0];
    p[1].npc        = ~pc;
    p[1].lphr       = ~pc[1:0];
    p[1].lphr_index = pc[19:10];
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a pop occurs this cycle when the head is valid and consumed.
  always @(negedge clk) begin
    if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_unexpected: got pc %0h expected no pop", out_pc_o);
      end else begin
        fetch_pkt_t e;
        e = exp_q.pop_front();
        if (out_pc_o === e.pc && out_predict_o === e.predict) n_pass++;
        else $display("FAIL pop_data: got pc %0h pred %0h expected pc %0h pred %0h",
                      out_pc_o, out_predict_o, e.pc, e.predict);
      end
    end
  end

  // One clock: apply inputs, record the hand-determined accept, advance past the edge.
  task automatic cyc(input logic v, input logic [PC_W-1:0] pc, input logic rdy,
                     input logic fl, input logic acc);
    fetch_pkt_t p;
    in_valid_i   = v;
    in_pc_i      = pc;
    in_predict_i = mk_pred(pc);
    out_ready_i  = rdy;
    flush_i      = fl;
    if (fl || !rst_n) exp_q.delete();
    if (acc) begin
      p.pc      = pc;
      p.predict = mk_pred(pc);
      exp_q.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic v, input logic r, input int c);
    chk({name, "_valid"}, 64'(out_valid_o), 64'(v));
    chk({name, "_ready"}, 64'(in_ready_o), 64'(r));
    chk({name, "_count"}, 64'(count_o), 64'(c));
  endtask

  initial begin
    // Reset then idle with out_ready_i high.
    rst_n = 1'b0;
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    rst_n = 1'b1;
    chk_state("reset", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 1, 0, 0);
      chk_state("idle", 0, 1, 0);
    end

    // Single push, head visible next cycle, then pop.
    cyc(1, 30'h0700_0000, 0, 0, 1);
    chk_state("single", 1, 1, 1);
    chk("single_pc", 64'(out_pc_o), 64'h0700_0000);
    cyc(0, '0, 1, 0, 0);
    chk_state("single_pop", 0, 1, 0);

    // Fill, blocked push while full with pop, then accepted next cycle.
    for (int i = 0; i < 4; i++) cyc(1, 30'(i), 0, 0, 1);
    chk_state("full", 1, 0, 4);
    cyc(1, 30'd9, 1, 0, 0);
    chk_state("full_pop", 1, 1, 3);
    cyc(1, 30'd9, 0, 0, 1);
    chk_state("refill", 1, 0, 4);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);
    chk_state("drained", 0, 1, 0);

    // Steady push/pop at count=2 across pointer wrap.
    cyc(1, 30'h100, 0, 0, 1);
    cyc(1, 30'h101, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 30'h102 + 30'(i), 1, 0, 1);
      chk("wrap_count", 64'(count_o), 64'd2);
    end
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk_state("wrap_drained", 0, 1, 0);

    // Flush at count=3 with simultaneous push and pop.
    for (int i = 0; i < 3; i++) cyc(1, 30'h200 + 30'(i), 0, 0, 1);
    chk("pre_flush_count", 64'(count_o), 64'd3);
    cyc(1, 30'h2ff, 1, 1, 0);
    chk_state("flush", 0, 1, 0);
    cyc(1, 30'h2ff, 1, 1, 0);
    chk_state("flush_held", 0, 1, 0);
    cyc(1, 30'h300, 0, 0, 1);
    chk_state("post_flush", 1, 1, 1);
    chk("post_flush_pc", 64'(out_pc_o), 64'h300);
    cyc(0, '0, 1, 0, 0);

    // Reset asserted while full.
    for (int i = 0; i < 4; i++) cyc(1, 30'h400 + 30'(i), 0, 0, 1);
    chk("pre_reset_count", 64'(count_o), 64'd4);
    rst_n = 1'b0;
    cyc(1, 30'h4ff, 1, 0, 0);
    rst_n = 1'b1;
    chk_state("mid_reset", 0, 1, 0);
    cyc(1, 30'h500, 0, 0, 1);
    chk_state("post_reset", 1, 1, 1);
    chk("post_reset_pc", 64'(out_pc_o), 64'h500);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_queue

`default_nettype wire
